// File: rtl/debounced_mode_select.sv
// Button conditioning (sync, debounce, edge pulses) feeding a mode/difficulty selector.
// Mode either latches on the lowest-index press (STICKY=1) or follows the lowest held button.
module debounced_mode_select #(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MODE_W          = 32,
    parameter int DEFAULT_MODE    = 0,
    parameter bit STICKY          = 1'b1
) (
    input  logic               clock,
    input  logic               anti_reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               enable,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [MODE_W-1:0]  mode_out,
    output logic               mode_valid,
    output logic               mode_changed
);

    localparam int                CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [MODE_W-1:0] MODE_DEFAULT = MODE_W'(DEFAULT_MODE);

    logic [NUM_BTN-1:0] sync_1;
    logic [NUM_BTN-1:0] sync_2;
    logic [CNT_W-1:0]   cnt      [NUM_BTN];
    logic [CNT_W-1:0]   cnt_next [NUM_BTN];
    logic [NUM_BTN-1:0] level_next;
    logic [MODE_W-1:0]  mode_next;
    logic               valid_next;

    // Lowest set index wins; an empty vector maps to the default code.
    function automatic logic [MODE_W-1:0] lowest_code(input logic [NUM_BTN-1:0] vec);
        logic [MODE_W-1:0] code;
        code = MODE_DEFAULT;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (vec[i]) code = MODE_W'(i + 1);
        end
        return code;
    endfunction

    always_comb begin
        level_next = btn_level;
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_next[i] = '0;
            if (sync_2[i] != btn_level[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    level_next[i] = sync_2[i];
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        mode_next  = mode_out;
        valid_next = mode_valid;
        if (enable) begin
            if (STICKY) begin
                if (|btn_press) begin
                    mode_next  = lowest_code(btn_press);
                    valid_next = 1'b1;
                end
            end else begin
                mode_next  = lowest_code(btn_level);
                valid_next = |btn_level;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!anti_reset) begin
            sync_1       <= '0;
            sync_2       <= '0;
            for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
            btn_level    <= '0;
            btn_press    <= '0;
            btn_release  <= '0;
            mode_out     <= MODE_DEFAULT;
            mode_valid   <= 1'b0;
            mode_changed <= 1'b0;
        end else begin
            sync_1       <= btn_raw;
            sync_2       <= sync_1;
            for (int i = 0; i < NUM_BTN; i++) cnt[i] <= cnt_next[i];
            btn_level    <= level_next;
            btn_press    <= level_next & ~btn_level;
            btn_release  <= ~level_next & btn_level;
            mode_out     <= mode_next;
            mode_valid   <= valid_next;
            mode_changed <= (mode_next != mode_out);
        end
    end

endmodule

// File: tb/tb_debounced_mode_select.sv
// Bench for debounced_mode_select: sticky and level-following instances share stimulus
// and are compared every cycle against a history-window reference model.
module tb_debounced_mode_select;

    localparam int NB = 5;
    localparam int DC = 4;
    localparam int MW = 32;

    logic          clock = 1'b0;
    logic          anti_reset = 1'b0;
    logic          enable = 1'b1;
    logic [NB-1:0] btn_raw = '0;

    logic [NB-1:0] lv_s, pr_s, rl_s, lv_f, pr_f, rl_f;
    logic [MW-1:0] mo_s, mo_f;
    logic          mv_s, mc_s, mv_f, mc_f;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    always #5 clock = ~clock;

    debounced_mode_select #(
        .NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .MODE_W(MW), .DEFAULT_MODE(0), .STICKY(1'b1)
    ) u_dut_s (
        .clock(clock), .anti_reset(anti_reset), .btn_raw(btn_raw), .enable(enable),
        .btn_level(lv_s), .btn_press(pr_s), .btn_release(rl_s),
        .mode_out(mo_s), .mode_valid(mv_s), .mode_changed(mc_s)
    );

    debounced_mode_select #(
        .NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .MODE_W(MW), .DEFAULT_MODE(0), .STICKY(1'b0)
    ) u_dut_f (
        .clock(clock), .anti_reset(anti_reset), .btn_raw(btn_raw), .enable(enable),
        .btn_level(lv_f), .btn_press(pr_f), .btn_release(rl_f),
        .mode_out(mo_f), .mode_valid(mv_f), .mode_changed(mc_f)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: a level is accepted once the synchronised input has shown the new
    // value on each of the last DC edges, all of them after the previous accepted change.
    logic [NB-1:0] raw_hist[$];
    logic [NB-1:0] s2_hist[$];
    int            n_edge;
    int            last_chg[NB];
    logic [NB-1:0] m_lvl, m_pr, m_rl, m_s2, m_nl;
    logic [31:0]   ms_mode, mf_mode, m_nm;
    logic          ms_valid, mf_valid, ms_chg, mf_chg;
    bit            m_stable;

    function automatic logic [31:0] lowest_code(input logic [NB-1:0] v);
        logic [31:0] r;
        r = 0;
        for (int i = NB - 1; i >= 0; i--) if (v[i]) r = i + 1;
        return r;
    endfunction

    always @(posedge clock) begin
        if (!anti_reset) begin
            raw_hist.delete();
            s2_hist.delete();
            n_edge = 0;
            for (int i = 0; i < NB; i++) last_chg[i] = -1;
            m_lvl = '0; m_pr = '0; m_rl = '0;
            ms_mode = 0; mf_mode = 0; ms_valid = 0; mf_valid = 0; ms_chg = 0; mf_chg = 0;
        end else begin
            m_s2 = (n_edge >= 2) ? raw_hist[n_edge-2] : '0;
            s2_hist.push_back(m_s2);
            raw_hist.push_back(btn_raw);

            m_nm = (enable && m_pr != 0) ? lowest_code(m_pr) : ms_mode;
            ms_chg = (m_nm != ms_mode);
            if (enable && m_pr != 0) ms_valid = 1'b1;
            ms_mode = m_nm;

            m_nm = enable ? lowest_code(m_lvl) : mf_mode;
            mf_chg = (m_nm != mf_mode);
            if (enable) mf_valid = |m_lvl;
            mf_mode = m_nm;

            m_nl = m_lvl;
            for (int i = 0; i < NB; i++) begin
                if (m_s2[i] != m_lvl[i] && (n_edge - last_chg[i]) >= DC) begin
                    m_stable = 1'b1;
                    for (int k = 0; k < DC; k++)
                        if (s2_hist[n_edge-k][i] != m_s2[i]) m_stable = 1'b0;
                    if (m_stable) begin
                        m_nl[i] = m_s2[i];
                        last_chg[i] = n_edge;
                    end
                end
            end
            m_pr  = m_nl & ~m_lvl;
            m_rl  = ~m_nl & m_lvl;
            m_lvl = m_nl;
            n_edge++;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("lvl_s", 32'(lv_s), 32'(m_lvl));
            check("press_s", 32'(pr_s), 32'(m_pr));
            check("rel_s", 32'(rl_s), 32'(m_rl));
            check("mode_s", mo_s, ms_mode);
            check("valid_s", 32'(mv_s), 32'(ms_valid));
            check("chg_s", 32'(mc_s), 32'(ms_chg));
            check("lvl_f", 32'(lv_f), 32'(m_lvl));
            check("press_f", 32'(pr_f), 32'(m_pr));
            check("rel_f", 32'(rl_f), 32'(m_rl));
            check("mode_f", mo_f, mf_mode);
            check("valid_f", 32'(mv_f), 32'(mf_valid));
            check("chg_f", 32'(mc_f), 32'(mf_chg));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    int press0_cnt;

    initial begin
        // 1: reset with all buttons held, then re-debounce after release
        btn_raw = '1;
        @(posedge clock);
        #1 chk_en = 1'b1;
        tick(3);
        check("rst_mode", mo_s, 0);
        check("rst_valid", 32'(mv_s), 0);
        check("rst_lvl", 32'(lv_s), 0);
        anti_reset = 1'b1;
        tick(8);
        check("hold_lvl", 32'(lv_s), 32'h1f);
        check("hold_mode", mo_s, 1);

        // 2: clean press of button 1 from a clean reset
        btn_raw = '0;
        anti_reset = 1'b0;
        tick(3);
        anti_reset = 1'b1;
        tick(8);
        btn_raw[1] = 1'b1;
        tick(10);
        check("clean_mode", mo_s, 2);
        check("clean_valid", 32'(mv_s), 1);

        // 3: bouncing button 0 yields exactly one press
        press0_cnt = 0;
        for (int t = 0; t < 20; t++) begin
            if (t % 2 == 0) btn_raw[0] = ~btn_raw[0];
            tick(1);
            if (pr_s[0]) press0_cnt++;
        end
        btn_raw[0] = 1'b1;
        for (int t = 0; t < 12; t++) begin
            tick(1);
            if (pr_s[0]) press0_cnt++;
        end
        check("bounce_presses", press0_cnt, 1);
        check("bounce_mode", mo_s, 1);

        // 4: simultaneous presses, lowest index wins
        btn_raw = '0;
        tick(10);
        btn_raw = 5'b00101;
        tick(10);
        check("simul_mode", mo_s, 1);

        // 5: sticky keeps mode on release, follow drops to default
        btn_raw = 5'b00010;
        tick(10);
        check("sel2_mode", mo_s, 2);
        btn_raw = '0;
        tick(10);
        check("sticky_keep", mo_s, 2);
        check("follow_mode", mo_f, 0);
        check("follow_valid", 32'(mv_f), 0);

        // 6: disabled press is not applied, reset mid-debounce discards progress
        enable = 1'b0;
        btn_raw[4] = 1'b1;
        tick(10);
        check("dis_mode", mo_s, 2);
        enable = 1'b1;
        tick(3);
        check("dis_late", mo_s, 2);
        btn_raw = '0;
        tick(10);
        btn_raw[3] = 1'b1;
        tick(4);
        anti_reset = 1'b0;
        tick(2);
        anti_reset = 1'b1;
        tick(3);
        check("abort_lvl", 32'(lv_s[3]), 0);
        tick(10);
        check("redeb_lvl", 32'(lv_s[3]), 1);
        check("redeb_mode", mo_s, 4);

        // 7: randomized bouncing, enable toggling and occasional resets
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 3) == 0) btn_raw[$urandom_range(0, NB-1)] ^= 1'b1;
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            anti_reset = ($urandom_range(0, 99) != 0);
            tick(1);
        end
        anti_reset = 1'b1;
        enable = 1'b1;
        tick(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
